// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Imported by the holding register and the divider top.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam int DIV_MIN = 2;

    // High-phase length: ceil(N/2)
    function automatic logic [31:0] hi_len(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/div_hold_reg.sv
// One-entry valid/ready holding register with a lower clamp.
// The owner empties the slot with a load strobe.
module div_hold_reg
    import clock_divider_pkg::*;
#(
    parameter int W   = 8,
    parameter int MIN = DIV_MIN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic         load,
    output logic [W-1:0] hold_data,
    output logic         full
);

    assign wr_ready = !full;

    // Capture and load never coincide: load needs full, capture needs empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 1'b0;
            hold_data <= '0;
        end else if (wr_valid && wr_ready) begin
            full      <= 1'b1;
            hold_data <= (wr_data < W'(MIN)) ? W'(MIN) : wr_data;
        end else if (load) begin
            full      <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_divider.sv
// Programmable integer clock divider with glitch-free divisor
// changes and start/stop; all outputs registered in clk_in domain.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [DIV_W-1:0] div_active,
    output logic             running
);

    state_t           state;
    state_t           next_state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] next_cnt;
    logic [DIV_W-1:0] next_div;
    logic [DIV_W-1:0] hi_next;
    logic [DIV_W-1:0] pend_div;
    logic             pend_full;
    logic             load;
    logic             wrap;
    logic             next_run;

    div_hold_reg #(
        .W   (DIV_W),
        .MIN (DIV_MIN)
    ) u_hold (
        .clk       (clk_in),
        .rst       (rst),
        .wr_data   (div_in),
        .wr_valid  (div_valid),
        .wr_ready  (div_ready),
        .load      (load),
        .hold_data (pend_div),
        .full      (pend_full)
    );

    always_comb begin
        next_state = state;
        next_cnt   = '0;
        wrap       = (cnt == div_active - DIV_W'(1));
        // Pending divisor only takes effect between periods
        load       = pend_full && (state == IDLE || wrap);
        next_div   = load ? pend_div : div_active;
        unique case (state)
            IDLE: begin
                if (en) next_state = RUN;
            end
            RUN: begin
                next_cnt = wrap ? '0 : cnt + DIV_W'(1);
                if (!en) next_state = STOPPING;
            end
            STOPPING: begin
                next_cnt = wrap ? '0 : cnt + DIV_W'(1);
                if (en)        next_state = RUN;
                else if (wrap) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        next_run = (next_state != IDLE);
        hi_next  = DIV_W'(hi_len(32'(next_div)));
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            div_active <= DIV_W'(DEFAULT_DIV);
            clk_out    <= 1'b0;
            rise_tick  <= 1'b0;
            fall_tick  <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            div_active <= next_div;
            clk_out    <= next_run && (next_cnt < hi_next);
            rise_tick  <= next_run && (next_cnt == '0);
            fall_tick  <= next_run && (next_cnt == hi_next);
            running    <= next_run;
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// Directed self-checking bench for clock_divider.
// Expected waveforms are derived from N and the phase index.
module tb_clock_divider;

    localparam int DIV_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             clk_out;
    logic             rise_tick;
    logic             fall_tick;
    logic [DIV_W-1:0] div_active;
    logic             running;

    int n_tests = 0;
    int n_fail  = 0;

    clock_divider #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_in     (clk),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .clk_out    (clk_out),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick),
        .div_active (div_active),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full period of N cycles with optional request / en changes
    task automatic period(input int n, input int req_idx, input int val,
                          input bit rdy0, input int off_idx,
                          input int on_idx);
        int hi;
        hi = n - n / 2;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            div_valid = 1'b0;
            chk("clk_out", 32'(clk_out), 32'(i < hi));
            chk("rise_tick", 32'(rise_tick), 32'(i == 0));
            chk("fall_tick", 32'(fall_tick), 32'(i == hi));
            chk("running", 32'(running), 32'd1);
            chk("div_active", 32'(div_active), 32'(n));
            if (i == 0)
                chk("div_ready_p0", 32'(div_ready), 32'(rdy0));
            if (req_idx >= 0 && i == req_idx + 1)
                chk("div_ready_busy", 32'(div_ready), 32'd0);
            if (i == req_idx) begin
                div_in    = DIV_W'(val);
                div_valid = 1'b1;
            end
            if (i == off_idx) en = 1'b0;
            if (i == on_idx)  en = 1'b1;
        end
    endtask

    task automatic idle_load(input int val, input int exp);
        div_in    = DIV_W'(val);
        div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        chk("idle_ready_busy", 32'(div_ready), 32'd0);
        @(posedge clk); #1;
        chk("idle_div_active", 32'(div_active), 32'(exp));
        chk("idle_ready_back", 32'(div_ready), 32'd1);
        chk("idle_clk_out", 32'(clk_out), 32'd0);
    endtask

    task automatic chk_idle(input int n);
        chk("idle_clk_out", 32'(clk_out), 32'd0);
        chk("idle_running", 32'(running), 32'd0);
        chk("idle_rise", 32'(rise_tick), 32'd0);
        chk("idle_div", 32'(div_active), 32'(n));
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        div_in    = '0;
        div_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle(4);
        chk("rst_fall", 32'(fall_tick), 32'd0);
        chk("rst_ready", 32'(div_ready), 32'd1);
        rst = 1'b0;

        // Default divide-by-4, then mid-period change to 5
        en = 1'b1;
        period(4, -1, 0, 1'b1, -1, -1);
        period(4, 0, 5, 1'b1, -1, -1);
        period(5, -1, 0, 1'b1, 4, -1);
        // en dropped at wrap: one more full period, then IDLE
        period(5, -1, 0, 1'b1, -1, -1);
        @(posedge clk); #1;
        chk_idle(5);

        // Clamp and load in IDLE
        idle_load(0, 2);
        idle_load(7, 7);
        idle_load(1, 2);

        // N=2, capture on a wrap cycle -> applied one period later
        en = 1'b1;
        period(2, -1, 0, 1'b1, -1, -1);
        period(2, 1, 6, 1'b1, -1, -1);
        period(2, -1, 0, 1'b0, -1, -1);
        // en=0 at cnt=0 with N=6
        period(6, -1, 0, 1'b1, 0, -1);
        @(posedge clk); #1;
        chk_idle(6);
        @(posedge clk); #1;
        chk_idle(6);

        // en off/on inside one period
        en = 1'b1;
        period(6, -1, 0, 1'b1, 0, 1);
        period(6, 5, 4, 1'b1, -1, -1);
        period(6, -1, 0, 1'b0, -1, -1);
        period(4, 3, 3, 1'b1, -1, -1);
        period(4, -1, 0, 1'b0, -1, -1);
        period(3, -1, 0, 1'b1, -1, -1);
        period(3, 2, 9, 1'b1, -1, -1);

        // Async reset while clk_out high with a divisor pending
        @(posedge clk); #1;
        div_valid = 1'b0;
        chk("pre_rst_clk", 32'(clk_out), 32'd1);
        chk("pre_rst_ready", 32'(div_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_idle(4);
        chk("async_rst_ready", 32'(div_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle(4);
        chk("post_rst_ready", 32'(div_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
